// File: rtl/viterbi_pkg.sv
// Shared decoder-datapath definitions used by the serializer/deserializer pair.
package viterbi_pkg;

    localparam int SYM_W_DEF  = 2;
    localparam int WORD_W_DEF = 16;

    typedef logic [SYM_W_DEF-1:0] sym_t;

    typedef struct packed {
        sym_t hi;
        sym_t lo;
    } sym_pair_t;

endpackage

// File: rtl/sipo.sv
// Serial-in/parallel-out deserializer: MSB-first symbols into words, with flush
// padding, a valid/ready output register and a sticky overflow flag.
module sipo
    import viterbi_pkg::*;
#(
    parameter int SYM_W  = SYM_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_serial_i,
    input  logic [SYM_W-1:0]                  data_serial_i,
    input  logic                              flush_i,
    input  logic                              ready_parallel_i,
    output logic [WORD_W-1:0]                 data_parallel_o,
    output logic                              valid_parallel_o,
    output logic                              partial_o,
    output logic [$clog2(WORD_W/SYM_W):0]     fill_o,
    output logic                              overflow_o
);

    localparam int N     = WORD_W / SYM_W;
    localparam int CNT_W = $clog2(N) + 1;

    localparam logic OUT_EMPTY = 1'b0;
    localparam logic OUT_FULL  = 1'b1;

    logic [WORD_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic              out_state;

    logic [WORD_W-1:0] sr_shift;
    logic [WORD_W-1:0] sr_incl;
    logic [WORD_W-1:0] offer_word;
    logic [CNT_W-1:0]  n_incl;
    logic              complete;
    logic              close;
    logic              offer;
    logic              offer_partial;

    // Left-align a word holding n symbols in its low bits.
    function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] w,
                                                   input logic [CNT_W-1:0]  n);
        int sh;
        sh = SYM_W * (N - int'(n));
        return w << sh;
    endfunction

    always_comb begin
        sr_shift      = {sr[WORD_W-SYM_W-1:0], data_serial_i};
        sr_incl       = valid_serial_i ? sr_shift : sr;
        n_incl        = cnt + CNT_W'(valid_serial_i);
        complete      = valid_serial_i && (cnt == CNT_W'(N - 1));
        close         = flush_i && (n_incl != '0);
        offer         = complete || close;
        offer_partial = !complete;
        offer_word    = complete ? sr_shift : pad_word(sr_incl, n_incl);
    end

    // Accumulator: never stalls, restarts after every offered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (offer) begin
            sr  <= '0;
            cnt <= '0;
        end else if (valid_serial_i) begin
            sr  <= sr_shift;
            cnt <= cnt + 1'b1;
        end
    end

    // Output register: a same-edge drain and refill keeps OUT_FULL without overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state       <= OUT_EMPTY;
            data_parallel_o <= '0;
            partial_o       <= 1'b0;
            overflow_o      <= 1'b0;
        end else if (offer) begin
            if (out_state == OUT_EMPTY || ready_parallel_i) begin
                out_state       <= OUT_FULL;
                data_parallel_o <= offer_word;
                partial_o       <= offer_partial;
            end else begin
                overflow_o <= 1'b1;
            end
        end else if (out_state == OUT_FULL && ready_parallel_i) begin
            out_state <= OUT_EMPTY;
        end
    end

    assign valid_parallel_o = (out_state == OUT_FULL);
    assign fill_o           = cnt;

endmodule

// File: tb/tb_sipo.sv
// Scoreboard bench for sipo: directed symbol streams, expected words queued by
// the stimulus and checked by an independent output monitor.
module tb_sipo;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_serial_i;
    logic [1:0]  data_serial_i;
    logic        flush_i;
    logic        ready_parallel_i;
    logic [15:0] data_parallel_o;
    logic        valid_parallel_o;
    logic        partial_o;
    logic [3:0]  fill_o;
    logic        overflow_o;

    int compared   = 0;
    int mismatched = 0;

    logic [16:0] exp_q[$];

    sipo dut (
        .clk              (clk),
        .rst              (rst),
        .valid_serial_i   (valid_serial_i),
        .data_serial_i    (data_serial_i),
        .flush_i          (flush_i),
        .ready_parallel_i (ready_parallel_i),
        .data_parallel_o  (data_parallel_o),
        .valid_parallel_o (valid_parallel_o),
        .partial_o        (partial_o),
        .fill_o           (fill_o),
        .overflow_o       (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted output word is popped and compared.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid_parallel_o === 1'b1 && ready_parallel_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_word: got %h partial %b, expected no word",
                         data_parallel_o, partial_o);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("word", {15'd0, partial_o, data_parallel_o}, {15'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [1:0] s, input logic fl);
        valid_serial_i = 1'b1;
        data_serial_i  = s;
        flush_i        = fl;
        tick();
        valid_serial_i = 1'b0;
        flush_i        = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit gaps, input bit chk_fill);
        for (int i = 0; i < 8; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_sym(w[15-2*i -: 2], 1'b0);
            if (chk_fill) check("fill", {28'd0, fill_o}, (i + 1) % 8);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: %0d words pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst              = 1'b1;
        valid_serial_i   = 1'b0;
        data_serial_i    = 2'b00;
        flush_i          = 1'b0;
        ready_parallel_i = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'd0, valid_parallel_o}, 0);
        check("rst_data", {16'd0, data_parallel_o}, 0);
        check("rst_fill", {28'd0, fill_o}, 0);
        check("rst_ovf", {31'd0, overflow_o}, 0);
        rst = 1'b0;

        // Single word
        exp_q.push_back({1'b0, 16'hA5A5});
        send_word(16'hA5A5, 1'b0, 1'b0);
        check("single_valid", {31'd0, valid_parallel_o}, 1);
        check("single_data", {16'd0, data_parallel_o}, 32'hA5A5);
        check("single_partial", {31'd0, partial_o}, 0);
        check("single_ovf", {31'd0, overflow_o}, 0);
        tick();
        check("single_valid_drop", {31'd0, valid_parallel_o}, 0);
        wait_drain("single");

        // Back-to-back with gaps
        exp_q.push_back({1'b0, 16'hA5A5});
        exp_q.push_back({1'b0, 16'hFFFF});
        send_word(16'hA5A5, 1'b1, 1'b1);
        send_word(16'hFFFF, 1'b1, 1'b1);
        wait_drain("gaps");

        // Stall and overflow
        ready_parallel_i = 1'b0;
        exp_q.push_back({1'b0, 16'hA5A5});
        send_word(16'hA5A5, 1'b0, 1'b0);
        check("stall_ovf_before", {31'd0, overflow_o}, 0);
        send_word(16'h1234, 1'b0, 1'b0);
        check("stall_hold_data", {16'd0, data_parallel_o}, 32'hA5A5);
        check("stall_hold_valid", {31'd0, valid_parallel_o}, 1);
        check("stall_ovf", {31'd0, overflow_o}, 1);
        check("stall_fill", {28'd0, fill_o}, 0);
        ready_parallel_i = 1'b1;
        tick();
        check("stall_drain_valid", {31'd0, valid_parallel_o}, 0);
        check("stall_ovf_sticky", {31'd0, overflow_o}, 1);
        wait_drain("stall");

        // Drain and refill on one edge
        do_reset();
        check("reset_clears_ovf", {31'd0, overflow_o}, 0);
        ready_parallel_i = 1'b0;
        exp_q.push_back({1'b0, 16'hA5A5});
        exp_q.push_back({1'b0, 16'h5A5A});
        send_word(16'hA5A5, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_sym((i % 4 < 2) ? 2'b01 : 2'b10, 1'b0);
        ready_parallel_i = 1'b1;
        send_sym(2'b10, 1'b0);
        check("refill_valid", {31'd0, valid_parallel_o}, 1);
        check("refill_data", {16'd0, data_parallel_o}, 32'h5A5A);
        check("refill_ovf", {31'd0, overflow_o}, 0);
        wait_drain("refill");

        // Flush without a symbol, with a symbol, and with nothing accumulated
        exp_q.push_back({1'b1, 16'hD800});
        send_sym(2'b11, 1'b0);
        send_sym(2'b01, 1'b0);
        send_sym(2'b10, 1'b0);
        check("flush_fill", {28'd0, fill_o}, 3);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_partial", {31'd0, partial_o}, 1);
        check("flush_fill_after", {28'd0, fill_o}, 0);
        wait_drain("flush0");
        exp_q.push_back({1'b1, 16'hDB00});
        send_sym(2'b11, 1'b0);
        send_sym(2'b01, 1'b0);
        send_sym(2'b10, 1'b0);
        send_sym(2'b11, 1'b1);
        wait_drain("flush1");
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_empty_valid", {31'd0, valid_parallel_o}, 0);
        tick();

        // Reset mid-word
        send_sym(2'b01, 1'b0);
        send_sym(2'b10, 1'b0);
        send_sym(2'b01, 1'b0);
        send_sym(2'b10, 1'b0);
        send_sym(2'b01, 1'b0);
        check("mid_fill", {28'd0, fill_o}, 5);
        do_reset();
        check("mid_rst_fill", {28'd0, fill_o}, 0);
        check("mid_rst_valid", {31'd0, valid_parallel_o}, 0);
        check("mid_rst_data", {16'd0, data_parallel_o}, 0);
        check("mid_rst_partial", {31'd0, partial_o}, 0);
        exp_q.push_back({1'b0, 16'hFFFF});
        send_word(16'hFFFF, 1'b0, 1'b0);
        check("mid_after_data", {16'd0, data_parallel_o}, 32'hFFFF);
        wait_drain("mid");
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sipo.md
# sipo

Serial-in/parallel-out deserializer for the decoder datapath: the receive-side counterpart of `piso`. It collects 2-bit symbols, MSB-first, into 16-bit words and presents each word on a registered output with a valid/ready handshake. It sits between the symbol stream (channel or loopback from `piso`) and word-oriented logic. It also provides a flush for partial words and a sticky overflow flag.

## Interface
- `SYM_W`, 2: bits per serial symbol.
- `WORD_W`, 16: parallel word width; must be an integer multiple of `SYM_W`. `N = WORD_W/SYM_W` = 8 symbols per word.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_serial_i`  in  1  `data_serial_i` holds a symbol this cycle.
- `data_serial_i`  in  SYM_W  serial symbol; the first symbol of a word lands in bits [WORD_W-1:WORD_W-SYM_W].
- `flush_i`  in  1  close the current partial word, zero-padding the low bits.
- `ready_parallel_i`  in  1  downstream accepts the output word.
- `data_parallel_o`  out  WORD_W  assembled word; stable while `valid_parallel_o && !ready_parallel_i`.
- `valid_parallel_o`  out  1  output register holds a word.
- `partial_o`  out  1  current output word was closed by flush (padded); qualified by valid.
- `fill_o`  out  clog2(N)+1  symbols held in the accumulator (0..N-1).
- `overflow_o`  out  1  sticky; a completed word was dropped.

## Operation
- **Accumulator.** Shift register `sr` plus counter `cnt`. An accepted symbol does `sr <= {sr[WORD_W-SYM_W-1:0], sym}` and `cnt <= cnt+1`.
- **Accumulator FSM.**
  - EMPTY (`cnt==0`) → FILL on a valid symbol.
  - FILL → EMPTY on the N-th symbol or on flush.
  - FILL self-loops otherwise.
- **Word completion.** With `cnt==N-1` and `valid_serial_i`, the word `{sr[WORD_W-SYM_W-1:0], sym}` is offered to the output register. In the same edge `cnt` becomes 0 and `partial` is 0.
- **Flush.**
  - `flush_i` with `cnt + valid_serial_i > 0` closes the word.
  - The same-cycle valid symbol is included first.
  - The word is left-aligned by shifting left `SYM_W*(N-n)`, where `n` is the symbol count after inclusion. `partial` is 1.
  - If `n==N`, it is a normal completion and `partial` is 0.
  - Flush with `cnt==0` and no valid symbol is a no-op.
- **Output FSM.**
  - OUT_EMPTY → OUT_FULL when a word is offered.
  - OUT_FULL → OUT_EMPTY on `ready_parallel_i` with no offer.
  - OUT_FULL self-loops when drained and refilled in the same edge (ready high and a word offered). This is not an overflow.
- **Overflow.** A word offered while OUT_FULL and `!ready_parallel_i` is discarded. The held word is unchanged, and `overflow_o` goes to 1 and stays there until `rst`. The accumulator still restarts at `cnt=0`.
- **Backpressure.** The accumulator never stalls; the serial input is always accepted.

## Timing
- **Reset values.** `rst` dominates all inputs. Reset values: `data_parallel_o=0`, `valid_parallel_o=0`, `partial_o=0`, `fill_o=0`, `overflow_o=0`, `sr=0`.
- **Reset mid-word.** A partial word present at reset is discarded.
- **Latency.** `valid_parallel_o` rises in the cycle after the edge that samples the N-th symbol (or the flush): 1 cycle.
- **Throughput.** 1 symbol/cycle sustained gives 1 word per N cycles. Gaps in `valid_serial_i` are allowed anywhere.
- **Hold.** `valid_parallel_o` stays high, and `data_parallel_o`/`partial_o` stay constant, until a cycle with `ready_parallel_i=1`.
- **Registered outputs.** `fill_o` reflects `cnt` after the edge; all outputs are registered.

## Structure
- Shared package `viterbi_pkg` holds the `SYM_W` and `WORD_W` defaults and a symbol-pair typedef, shared with `piso`.
- Single module; no sub-module needed. The pad shifter is a small combinational function inside `sipo`.

## Test plan
- **Single word.** Symbols 10,10,01,01,10,10,01,01 on consecutive cycles, `ready=1`:
  - one cycle after the 8th symbol, `data_parallel_o=16'hA5A5`, valid for 1 cycle, `partial_o=0`, `overflow_o=0`.
- **Back-to-back with gaps.** 0xA5A5 then 0xFFFF with random `valid_serial_i` gaps, `ready=1`:
  - both words delivered in order; `fill_o` counts 0..7 and wraps.
- **Stall and overflow.** `ready=0`; send 0xA5A5, then 0x1234:
  - `data_parallel_o` stays 0xA5A5 and `overflow_o=1` after the 0x1234 completion.
  - Raise ready: 0xA5A5 drains, valid drops, `overflow_o` stays 1.
- **Drain and refill on one edge.** Held word, then ready=1 on the same cycle as the 8th symbol of 0x5A5A:
  - next cycle valid=1 with 0x5A5A, `overflow_o=0`.
- **Flush.**
  - 11,01,10 then flush with no symbol → 16'hD800, `partial_o=1`.
  - 11,01,10 then flush with valid symbol 11 → 16'hDB00, `partial_o=1`.
  - Flush at `cnt=0` → no output.
- **Reset mid-word.** Assert `rst` after 5 symbols:
  - all outputs 0.
  - Then 8×11 → exactly 0xFFFF, with no residue from the aborted word.
- **Optional loopback.** `piso` → `sipo` round-trips random words unchanged.
